// File: rtl/spi_arb.sv
// Two-port round-robin arbiter and transaction sequencer in front of spi_if.
// Drives spi_if request pins, waits for ready, and returns data/ack/err with a watchdog.
module spi_arb #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int TMO_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_in,
    input  logic              we0_in,
    input  logic              wide0_in,
    input  logic [DATA_W-1:0] wdata0_in,
    output logic              ack0_out,
    input  logic              req1_in,
    input  logic              we1_in,
    input  logic              wide1_in,
    input  logic [DATA_W-1:0] wdata1_in,
    output logic              ack1_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err_out,
    output logic              busy_out,
    output logic              spi_send_out,
    output logic              spi_read_out,
    output logic              spi_drv_io_out,
    output logic [DATA_W-1:0] spi_wdata_out,
    input  logic              spi_ready_in,
    input  logic [DATA_W-1:0] spi_rdata_in
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic                wide_q, wide_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                pick;
    logic                tmo_hit;
    logic                active;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign active  = (state_q == ISSUE) || (state_q == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            wide_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            wide_q  <= wide_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        wide_d  = wide_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        pick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_in || req1_in) begin
                    pick    = (req0_in && req1_in) ? rr_q : req1_in;
                    gnt_d   = pick;
                    we_d    = pick ? we1_in : we0_in;
                    wide_d  = pick ? wide1_in : wide0_in;
                    wdata_d = pick ? wdata1_in : wdata0_in;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // ready takes precedence over a coincident watchdog expiry
                if (spi_ready_in) begin
                    if (!we_q) rdata_d = spi_rdata_in;
                    err_d   = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                rr_d    = ~gnt_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        spi_send_out   = (state_q == ISSUE) && we_q;
        spi_read_out   = active && !we_q;
        spi_drv_io_out = active && wide_q;
        spi_wdata_out  = active ? wdata_q : '0;
    end

    assign ack0_out  = ack0_q;
    assign ack1_out  = ack1_q;
    assign err_out   = err_q;
    assign rdata_out = rdata_q;
    assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_arb.sv
// Randomized scoreboard bench for spi_arb with an spi_if responder and
// a transaction-level arbitration/response model.
module tb_spi_arb;

    localparam int DW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_in = 1'b0, we0_in = 1'b0, wide0_in = 1'b0;
    logic [DW-1:0] wdata0_in = '0;
    logic          req1_in = 1'b0, we1_in = 1'b0, wide1_in = 1'b0;
    logic [DW-1:0] wdata1_in = '0;
    logic          ack0_out, ack1_out, err_out, busy_out;
    logic [DW-1:0] rdata_out, spi_wdata_out;
    logic          spi_send_out, spi_read_out, spi_drv_io_out;
    logic          spi_ready_in = 1'b0;
    logic [DW-1:0] spi_rdata_in = '0;

    spi_arb #(.DATA_W(DW), .TIMEOUT_CYC(TMO), .TMO_W(7)) dut (
        .clk(clk), .rst(rst),
        .req0_in(req0_in), .we0_in(we0_in), .wide0_in(wide0_in),
        .wdata0_in(wdata0_in), .ack0_out(ack0_out),
        .req1_in(req1_in), .we1_in(we1_in), .wide1_in(wide1_in),
        .wdata1_in(wdata1_in), .ack1_out(ack1_out),
        .rdata_out(rdata_out), .err_out(err_out), .busy_out(busy_out),
        .spi_send_out(spi_send_out), .spi_read_out(spi_read_out),
        .spi_drv_io_out(spi_drv_io_out), .spi_wdata_out(spi_wdata_out),
        .spi_ready_in(spi_ready_in), .spi_rdata_in(spi_rdata_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            port;
        bit            err;
        logic [DW-1:0] rd;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            dly_q[$];
    logic [DW-1:0] dat_q[$];

    // responder delay: 0 = never ready, else ready in that WAIT cycle
    function automatic int rand_dly();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TMO;
        if (r == 2) return TMO - 1;
        return $urandom_range(1, 10);
    endfunction

    // issue monitor + spi_if responder + arbitration model
    bit            pb, pr0, pr1, act, rr_m;
    bit            c_we, c_wide;
    logic [DW-1:0] c_wd, last_rd, rdat;
    int            wc, d, nw, cur_p;
    exp_t          e;

    always @(negedge clk) begin
        if (!rst) begin
            act = 0;
            rr_m = 0;
            last_rd = '0;
            sb.delete();
            spi_ready_in = 1'b0;
        end else begin
            spi_ready_in = 1'b0;
            if (busy_out && !pb) begin
                chk("grant_has_req", 32'(pr0 | pr1), 32'd1);
                cur_p  = (pr0 && pr1) ? int'(rr_m) : int'(pr1);
                rr_m   = !cur_p[0];
                c_we   = cur_p ? we1_in : we0_in;
                c_wide = cur_p ? wide1_in : wide0_in;
                c_wd   = cur_p ? wdata1_in : wdata0_in;
                d      = dly_q.size() > 0 ? dly_q.pop_front() : rand_dly();
                rdat   = dat_q.size() > 0 ? dat_q.pop_front() : DW'($urandom);
                spi_rdata_in = rdat;
                chk("issue_send", 32'(spi_send_out), 32'(c_we));
                chk("issue_read", 32'(spi_read_out), 32'(!c_we));
                chk("issue_drv", 32'(spi_drv_io_out), 32'(c_wide));
                chk("issue_wdata", 32'(spi_wdata_out), 32'(c_wd));
                nw = (d >= 1 && d <= TMO) ? d : TMO;
                e.port = cur_p;
                e.cyc  = cyc + nw + 1;
                if (d >= 1 && d <= TMO) begin
                    e.err = 1'b0;
                    e.rd  = c_we ? last_rd : rdat;
                end else begin
                    e.err = 1'b1;
                    e.rd  = '0;
                end
                last_rd = e.rd;
                sb.push_back(e);
                act = 1;
                wc = 0;
            end else if (busy_out && act) begin
                wc++;
                if (wc <= nw) begin
                    if (spi_send_out !== 1'b0 || spi_read_out !== !c_we ||
                        spi_drv_io_out !== c_wide || spi_wdata_out !== c_wd)
                        chk("wait_pins", {spi_send_out, spi_read_out,
                            spi_drv_io_out, spi_wdata_out},
                            {1'b0, !c_we, c_wide, c_wd});
                    spi_ready_in = (wc == d);
                end else begin
                    chk("resp_pins", {21'd0, spi_send_out, spi_read_out,
                        spi_drv_io_out, spi_wdata_out}, 32'd0);
                    act = 0;
                end
            end
        end
        pb  = busy_out;
        pr0 = req0_in;
        pr1 = req1_in;
    end

    // ack monitor: pops the scoreboard on every ack
    exp_t g;
    always @(negedge clk) begin
        if (rst && (ack0_out || ack1_out)) begin
            chk("ack_onehot", 32'(ack0_out & ack1_out), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none",
                         ack0_out, ack1_out);
            end else begin
                g = sb.pop_front();
                chk("ack_port", 32'(ack1_out), 32'(g.port));
                chk("ack_err", 32'(err_out), 32'(g.err));
                chk("ack_rdata", 32'(rdata_out), 32'(g.rd));
                chk("ack_cycle", 32'(cyc), 32'(g.cyc));
            end
        end
    end

    task automatic set_port(int p, logic r, logic w, logic wd, logic [DW-1:0] dat);
        if (p == 0) begin
            req0_in = r; we0_in = w; wide0_in = wd; wdata0_in = dat;
        end else begin
            req1_in = r; we1_in = w; wide1_in = wd; wdata1_in = dat;
        end
    endtask

    task automatic port_run(int p, int n, bit rnd, logic w, logic wd,
                            logic [DW-1:0] dat, bit gap);
        int t;
        logic a;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd) set_port(p, 1'b1, 1'($urandom), 1'($urandom), DW'($urandom));
            else     set_port(p, 1'b1, w, wd, dat);
            t = 0;
            a = 1'b0;
            while (!a && t < 400) begin
                @(posedge clk);
                #1;
                t++;
                a = p ? ack1_out : ack0_out;
            end
            if (!a) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_timeout: port %0d got no ack expected one", p);
            end
            if (gap) begin
                set_port(p, 1'b0, 1'b0, 1'b0, '0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        #1;
        set_port(p, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_zero(string nm);
        chk(nm, {22'd0, ack0_out, ack1_out, err_out, busy_out, spi_send_out,
                 spi_read_out, spi_drv_io_out, 3'd0}, 32'd0);
        chk({nm, "_data"}, {16'd0, rdata_out, spi_wdata_out}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outs");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // single read, ready 8 cycles after ISSUE
        dly_q.push_back(8);
        dat_q.push_back(8'hA5);
        port_run(0, 1, 0, 1'b0, 1'b0, 8'h00, 1);

        // wide write on port 1
        dly_q.push_back(4);
        port_run(1, 1, 0, 1'b1, 1'b1, 8'h3C, 1);

        // contention, both held continuously
        repeat (4) dly_q.push_back(3);
        fork
            port_run(0, 2, 1, 1'b0, 1'b0, 8'h00, 0);
            port_run(1, 2, 1, 1'b0, 1'b0, 8'h00, 0);
        join

        // watchdog expiry, then ready on the limit cycle
        dly_q.push_back(0);
        port_run(0, 1, 0, 1'b0, 1'b0, 8'h11, 1);
        dly_q.push_back(TMO);
        dat_q.push_back(8'h5A);
        port_run(1, 1, 0, 1'b0, 1'b1, 8'h22, 1);

        // reset during WAIT, pending req0 re-served afterwards
        dly_q.push_back(0);
        fork
            port_run(0, 1, 0, 1'b0, 1'b0, 8'h33, 1);
            begin
                repeat (12) @(posedge clk);
                #3;
                rst = 1'b0;
                #1;
                chk_zero("midreset_outs");
                dly_q.push_back(5);
                dat_q.push_back(8'hC3);
                @(posedge clk);
                #2;
                rst = 1'b1;
            end
        join

        // randomized traffic on both ports
        fork
            port_run(0, 15, 1, 1'b0, 1'b0, 8'h00, 1);
            port_run(1, 15, 1, 1'b0, 1'b0, 8'h00, 1);
        join

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Sequencer and two-port arbiter placed in front of the SPI interface block (spi_if).
- Port 0 (core load/store path) and port 1 (auxiliary/boot loader) each issue whole SPI transactions: a read, or a write of DATA_W bits, optionally in wide address+data mode.
- The block grants one port at a time using round-robin priority.
- It drives spi_if's request pins with the exact timing that block requires, waits for completion, and returns read data, an acknowledge and an error flag per port.
- A watchdog aborts any transaction that never completes.

Parameters:
- DATA_W, 8, width of SPI data word.
- TIMEOUT_CYC, 64, maximum cycles in WAIT before abort. Must be ≥ 2 and greater than DATA_W+address bits+2.
- TMO_W, 7, width of watchdog counter. Must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req0_in  in  1  port 0 request; held until ack0_out.
- we0_in  in  1  port 0: 1=write, 0=read; stable while req0_in.
- wide0_in  in  1  port 0: 1=address+data frame (driver_io mode).
- wdata0_in  in  DATA_W  port 0 write data.
- ack0_out  out  1  port 0 one-cycle completion pulse.
- req1_in / we1_in / wide1_in / wdata1_in / ack1_out: same as port 0, for port 1.
- rdata_out  out  DATA_W  read data, valid in the ack cycle; shared by both ports.
- err_out  out  1  valid with ack; 1 = transaction timed out.
- busy_out  out  1  1 whenever state != IDLE.
- spi_send_out  out  1  to spi_if send_in.
- spi_read_out  out  1  to spi_if read_in.
- spi_drv_io_out  out  1  to spi_if driver_io_in.
- spi_wdata_out  out  DATA_W  to spi_if data_in.
- spi_ready_in  in  1  from spi_if ready_out.
- spi_rdata_in  in  DATA_W  from spi_if data_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr pointer=0 (port 0 favoured), watchdog=0.
  - All outputs 0, including rdata_out and the latched grant, we, wide and wdata registers.
- FSM states: IDLE, ISSUE, WAIT, RESP. Transitions occur on posedge clk.
- IDLE:
  - If neither request is set, stay.
  - If exactly one request is set, grant it.
  - If both are set, grant the port equal to the rr pointer.
  - Latch grant, we, wide and wdata from the granted port, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Write: spi_send_out=1 for this cycle only.
  - Read: spi_read_out=1.
  - spi_drv_io_out=latched wide; spi_wdata_out=latched wdata.
  - Watchdog cleared. Next state is WAIT.
- WAIT:
  - spi_read_out stays 1 for reads, because spi_if shifts MISO only while read_in is high. It is 0 for writes.
  - spi_drv_io_out and spi_wdata_out are held.
  - spi_send_out is 0.
  - Watchdog increments each cycle.
- WAIT exits:
  - spi_ready_in=1: capture rdata_out = spi_rdata_in for reads (rdata_out unchanged for writes), err=0, go to RESP.
  - Otherwise, when watchdog == TIMEOUT_CYC-1: rdata_out=0, err=1, go to RESP.
  - If ready and timeout occur in the same cycle, ready wins and err=0.
- RESP (exactly 1 cycle):
  - ackN_out=1 for the granted port only; err_out=latched err.
  - All spi_* request outputs are 0.
  - rr pointer = ~granted port.
  - Next state is IDLE. No new grant is made in this cycle, which gives spi_if a one-cycle idle gap.
- Latency: a read or write with no contention has ack at cycle 2+N after the request is sampled in IDLE, where N is the number of WAIT cycles up to and including the ready cycle.
- Request deasserted mid-transaction: ignored. The transaction completes and the ack is still pulsed.
- Requester may re-raise req in the cycle after its ack. It is arbitrated normally, and the rr pointer now favours the other port.
- err_out, rdata_out and the ack outputs are registered. rdata_out holds its value until the next capture.
- Reset mid-transaction: immediate return to IDLE with all spi_* outputs 0. No ack is generated.
- At most one ack is asserted per cycle, and never two consecutive RESP cycles.

Test Plan:
- Reset, then a single read on port 0 with spi_ready_in pulsed 8 cycles after ISSUE, spi_rdata_in=8'hA5 → spi_read_out is high from ISSUE through the ready cycle; ack0_out pulses once; rdata_out=8'hA5; err_out=0; ack1_out stays 0.
- Port 1 write, wide=1, wdata=8'h3C → spi_send_out high for exactly 1 cycle with spi_wdata_out=8'h3C and spi_drv_io_out=1; spi_read_out=0 throughout; ack1_out follows the ready pulse by 1 cycle.
- Both ports request in the same cycle after reset, held continuously → grants alternate 0,1,0,1 across 4 transactions, with one IDLE cycle between each RESP and the next ISSUE.
- spi_ready_in never asserted, TIMEOUT_CYC=64 → ack pulses 64 WAIT cycles after ISSUE with err_out=1 and rdata_out=0; the next request is served normally.
- spi_ready_in rises in the same cycle the watchdog hits its limit → err_out=0 and data is captured.
- rst driven low during WAIT, between clock edges → all outputs 0 immediately, no ack; after release, a pending req0_in is granted and completes normally.
